playfield_collision: RTL and testbench
======================================

# playfield_collision

Raster-synchronous playfield scanner that sits between the VGA timing generator and `game_logic`. Per pixel it classifies border, brick, paddle and ball. It produces the per-pixel collision strobes that `game_logic` latches (`collision`, edge flags, `paddle_collision`, `paddle_segment`) and generates `frame_pulse`. It owns the brick map: bricks hit by the ball are cleared, and the remaining-brick count is maintained.

## Interface
Parameters:
- `BORDER_WIDTH`, 8: border thickness in pixels (left, right and top walls).
- `BALL_SIZE`, 4: ball edge length in pixels; `ball_x`/`ball_y` give the top-left corner.
- `PADDLE_WIDTH`, 64: paddle width in pixels.
- `PADDLE_Y`, 452: first paddle row.
- `PADDLE_HEIGHT`, 8: paddle height in rows.
- `BRICK_LEFT`, 64: x of the brick grid's left edge.
- `BRICK_TOP`, 64: y of the brick grid's top edge.
- `BRICK_COLS`, 16: grid columns, each 32 px wide.
- `BRICK_ROWS`, 8: grid rows, each 16 px high.
- `FRAME_PULSE_LINE`, 480: `vpos` value at which `frame_pulse` fires.

Ports:
- `clk` in 1: pixel clock.
- `rst` in 1: reset; asynchronous, active-high.
- `hpos` in 10: current pixel x.
- `vpos` in 10: current pixel y.
- `visible` in 1: active display area.
- `ball_x` in 10, `ball_y` in 9, `paddle_x` in 10: positions from `game_logic`.
- `restore_bricks` in 1: one-cycle request to refill the brick map.
- `frame_pulse` out 1: one-cycle end-of-frame strobe.
- `collision` out 1: a ball pixel overlaps a solid pixel.
- `ball_top_col`, `ball_bottom_col`, `ball_left_col`, `ball_right_col` out 1 each: the overlapping pixel lies on that ball edge.
- `paddle_collision` out 1: the overlap is with the paddle.
- `paddle_segment` out 3: paddle zone 0–5 of the current pixel.
- `is_border`, `is_brick`, `is_paddle`, `is_ball` out 1 each: pixel classification for the renderer.
- `bricks_remaining` out 8: number of live bricks.
- `all_cleared` out 1: `bricks_remaining == 0`.

## Operation
Region tests are combinational on `hpos`/`vpos`. All comparisons use 11-bit unsigned arithmetic (`ball_x + BALL_SIZE`, `paddle_x + PADDLE_WIDTH`) so nothing wraps. Every region is gated by `visible`.

- Border: `hpos < BORDER_WIDTH`, or `hpos >= 640-BORDER_WIDTH`, or `vpos < BORDER_WIDTH`.
- Paddle: `vpos` in [`PADDLE_Y`, `PADDLE_Y+PADDLE_HEIGHT`) and `hpos` in [`paddle_x`, `paddle_x+PADDLE_WIDTH`).
- Ball: `hpos` in [`ball_x`, `+BALL_SIZE`) and `vpos` in [`ball_y`, `+BALL_SIZE`).
  - dx = `hpos-ball_x`, dy = `vpos-ball_y`.
  - Edge flags: top when dy==0, bottom when dy==`BALL_SIZE-1`, left when dx==0, right when dx==`BALL_SIZE-1`.
- Brick: pixel lies inside the grid at column `(hpos-BRICK_LEFT)>>5` and row `(vpos-BRICK_TOP)>>4`, and the corresponding map bit is 1.
  - The map is `BRICK_ROWS*BRICK_COLS` flops, index = row*`BRICK_COLS`+col.
- Paddle segment from offset o = `hpos-paddle_x`:
  - 0 if o<11; 1 if o<22; 2 if o<32; 3 if o<42; 4 if o<53; else 5.
  - Outside the paddle the segment is 0.
- `collision` = ball & (border | brick | paddle). Edge flags are asserted only when `collision` is asserted.
- `paddle_collision` = ball & paddle. `paddle_segment` is valid whenever `paddle_collision` is 1.
- Brick clear: a ball pixel that overlaps a live brick clears that brick's bit at the next edge and decrements `bricks_remaining` once. Later pixels of the same brick then see bit=0, so there is no double count.
- Restore: `restore_bricks` sets all bits to 1 and `bricks_remaining` to `BRICK_ROWS*BRICK_COLS`. Restore beats a clear in the same cycle.
- `frame_pulse` fires when `hpos==0 && vpos==FRAME_PULSE_LINE`, independent of `visible`.

## Timing
- All outputs are registered, with 1-cycle latency from the `hpos`/`vpos` sample.
- Brick map and count update on the same edge that registers the corresponding `is_brick`/`collision` output.
- `frame_pulse` is exactly one cycle wide, once per frame.
- Reset values:
  - All strobes, flags, `is_*` outputs and `paddle_segment` are 0.
  - Brick map is all 1s; `bricks_remaining` = 128.
  - `all_cleared` = 0.
- Reset asserted mid-frame takes effect immediately. Scanning resumes on the first edge after release, with no partial state kept.
- `all_cleared` follows `bricks_remaining` combinationally from the register, so it has no extra latency.
- `ball_x`, `ball_y` and `paddle_x` are assumed stable between `frame_pulse`s. No internal capture is done.

## Test plan
- Reset: assert `rst`, scan a full frame with the ball off-grid.
  - `bricks_remaining`=128, `all_cleared`=0.
  - `frame_pulse` is high exactly one cycle after sampling (0,480); no collisions.
- Left wall: `ball_x`=6, `ball_y`=200.
  - `collision`=1 for `hpos` 6,7 × `vpos` 200–203 (one cycle late).
  - `ball_left_col` only at `hpos`=6; `ball_top_col` only at `vpos`=200; `ball_right_col` never.
- Paddle: `paddle_x`=288, ball at (320,450).
  - `paddle_collision`=1 and `paddle_segment`=3 at `vpos` 452–453, `hpos` 320–323.
  - `ball_bottom_col`=1 only at `vpos`=453.
- Brick hit: ball at (100,70).
  - Brick row 0, col 1 is cleared; `bricks_remaining`=127.
  - Next frame `is_brick`=0 over x 96–127, y 64–79; count stays 127.
- Restore race: `restore_bricks` in the same cycle as a brick clear gives `bricks_remaining`=128 and all bits set.
- Blanking: ball overlapping the border with `visible`=0 gives no `collision`, no `is_*`, and no brick change.

Source files
------------

// File: rtl/playfield_collision.sv
// Raster-synchronous playfield classifier, collision strobes and brick map.
// Owns the brick bitmap and live-brick count; all outputs are registered.
module playfield_collision #(
  parameter int BORDER_WIDTH     = 8,
  parameter int BALL_SIZE        = 4,
  parameter int PADDLE_WIDTH     = 64,
  parameter int PADDLE_Y         = 452,
  parameter int PADDLE_HEIGHT    = 8,
  parameter int BRICK_LEFT       = 64,
  parameter int BRICK_TOP        = 64,
  parameter int BRICK_COLS       = 16,
  parameter int BRICK_ROWS       = 8,
  parameter int FRAME_PULSE_LINE = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       visible,
  input  logic [9:0] ball_x,
  input  logic [8:0] ball_y,
  input  logic [9:0] paddle_x,
  input  logic       restore_bricks,
  output logic       frame_pulse,
  output logic       collision,
  output logic       ball_top_col,
  output logic       ball_bottom_col,
  output logic       ball_left_col,
  output logic       ball_right_col,
  output logic       paddle_collision,
  output logic [2:0] paddle_segment,
  output logic       is_border,
  output logic       is_brick,
  output logic       is_paddle,
  output logic       is_ball,
  output logic [7:0] bricks_remaining,
  output logic       all_cleared
);

  localparam int NB     = BRICK_ROWS * BRICK_COLS;
  localparam int IW     = (NB > 1) ? $clog2(NB) : 1;
  localparam int GRID_W = BRICK_COLS * 32;
  localparam int GRID_H = BRICK_ROWS * 16;

  localparam logic [10:0] BW_L   = 11'(BORDER_WIDTH);
  localparam logic [10:0] BW_R   = 11'(640 - BORDER_WIDTH);
  localparam logic [10:0] BS     = 11'(BALL_SIZE);
  localparam logic [10:0] BS_M1  = 11'(BALL_SIZE - 1);
  localparam logic [10:0] PW     = 11'(PADDLE_WIDTH);
  localparam logic [10:0] PY_LO  = 11'(PADDLE_Y);
  localparam logic [10:0] PY_HI  = 11'(PADDLE_Y + PADDLE_HEIGHT);
  localparam logic [10:0] GX_LO  = 11'(BRICK_LEFT);
  localparam logic [10:0] GX_HI  = 11'(BRICK_LEFT + GRID_W);
  localparam logic [10:0] GY_LO  = 11'(BRICK_TOP);
  localparam logic [10:0] GY_HI  = 11'(BRICK_TOP + GRID_H);
  localparam logic [10:0] COLS_L = 11'(BRICK_COLS);
  localparam logic [9:0]  FP_V   = 10'(FRAME_PULSE_LINE);
  localparam logic [7:0]  NB_CNT = 8'(NB);

  // widened coordinates so that end-of-range sums never wrap
  logic [10:0] h, v, bx, by, pxl;
  logic [10:0] bx_end, by_end, px_end;
  logic [10:0] dx, dy, po, gx, gy, idx_full;
  logic [IW-1:0] brick_idx;

  logic border_c, paddle_c, ball_c, in_grid, brick_c;
  logic hit_c, coll_c, pcoll_c, fp_c;
  logic [2:0] seg_c;

  logic [NB-1:0] map_q, map_d;
  logic [7:0]    cnt_q, cnt_d;

  logic fp_q, coll_q, top_q, bot_q, left_q, right_q;
  logic pcoll_q, border_q, brick_q, paddle_q, ball_q;
  logic [2:0] seg_q;

  // per-pixel region classification
  always_comb begin
    h      = {1'b0, hpos};
    v      = {1'b0, vpos};
    bx     = {1'b0, ball_x};
    by     = {2'b0, ball_y};
    pxl    = {1'b0, paddle_x};
    bx_end = bx + BS;
    by_end = by + BS;
    px_end = pxl + PW;
    dx     = h - bx;
    dy     = v - by;
    po     = h - pxl;
    gx     = h - GX_LO;
    gy     = v - GY_LO;

    border_c = visible &&
               (h < BW_L || h >= BW_R || v < BW_L);
    paddle_c = visible &&
               v >= PY_LO && v < PY_HI &&
               h >= pxl && h < px_end;
    ball_c   = visible &&
               h >= bx && h < bx_end &&
               v >= by && v < by_end;
    in_grid  = visible &&
               h >= GX_LO && h < GX_HI &&
               v >= GY_LO && v < GY_HI;

    idx_full  = (gy >> 4) * COLS_L + (gx >> 5);
    brick_idx = idx_full[IW-1:0];
    brick_c   = in_grid && map_q[brick_idx];

    hit_c   = ball_c && brick_c;
    coll_c  = ball_c && (border_c || brick_c || paddle_c);
    pcoll_c = ball_c && paddle_c;
    fp_c    = (hpos == 10'd0) && (vpos == FP_V);
  end

  // paddle zone of the current pixel, zero off the paddle
  always_comb begin
    seg_c = 3'd0;
    if (paddle_c) begin
      if (po < 11'd11)      seg_c = 3'd0;
      else if (po < 11'd22) seg_c = 3'd1;
      else if (po < 11'd32) seg_c = 3'd2;
      else if (po < 11'd42) seg_c = 3'd3;
      else if (po < 11'd53) seg_c = 3'd4;
      else                  seg_c = 3'd5;
    end
  end

  // brick map next state: refill wins over a clear in the same cycle
  always_comb begin
    map_d = map_q;
    cnt_d = cnt_q;
    if (restore_bricks) begin
      map_d = '1;
      cnt_d = NB_CNT;
    end else if (hit_c) begin
      map_d[brick_idx] = 1'b0;
      cnt_d = cnt_q - 8'd1;
    end
  end

  // brick map and live count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      map_q <= '1;
      cnt_q <= NB_CNT;
    end else begin
      map_q <= map_d;
      cnt_q <= cnt_d;
    end
  end

  // registered strobes and classification, one cycle behind the raster
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fp_q     <= 1'b0;
      coll_q   <= 1'b0;
      top_q    <= 1'b0;
      bot_q    <= 1'b0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      pcoll_q  <= 1'b0;
      seg_q    <= 3'd0;
      border_q <= 1'b0;
      brick_q  <= 1'b0;
      paddle_q <= 1'b0;
      ball_q   <= 1'b0;
    end else begin
      fp_q     <= fp_c;
      coll_q   <= coll_c;
      top_q    <= coll_c && (dy == 11'd0);
      bot_q    <= coll_c && (dy == BS_M1);
      left_q   <= coll_c && (dx == 11'd0);
      right_q  <= coll_c && (dx == BS_M1);
      pcoll_q  <= pcoll_c;
      seg_q    <= seg_c;
      border_q <= border_c;
      brick_q  <= brick_c;
      paddle_q <= paddle_c;
      ball_q   <= ball_c;
    end
  end

  assign frame_pulse      = fp_q;
  assign collision        = coll_q;
  assign ball_top_col     = top_q;
  assign ball_bottom_col  = bot_q;
  assign ball_left_col    = left_q;
  assign ball_right_col   = right_q;
  assign paddle_collision = pcoll_q;
  assign paddle_segment   = seg_q;
  assign is_border        = border_q;
  assign is_brick         = brick_q;
  assign is_paddle        = paddle_q;
  assign is_ball          = ball_q;
  assign bricks_remaining = cnt_q;
  assign all_cleared      = (cnt_q == 8'd0);

endmodule

// File: tb/tb_playfield_collision.sv
// Directed bench for playfield_collision.
// Drives single raster pixels and checks the registered outputs.
module tb_playfield_collision;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] hpos, vpos;
  logic       visible;
  logic [9:0] ball_x, paddle_x;
  logic [8:0] ball_y;
  logic       restore_bricks;
  logic       frame_pulse, collision;
  logic       ball_top_col, ball_bottom_col;
  logic       ball_left_col, ball_right_col;
  logic       paddle_collision;
  logic [2:0] paddle_segment;
  logic       is_border, is_brick, is_paddle, is_ball;
  logic [7:0] bricks_remaining;
  logic       all_cleared;

  int n_checks = 0;
  int n_errors = 0;

  playfield_collision dut (
    .clk              (clk),
    .rst              (rst),
    .hpos             (hpos),
    .vpos             (vpos),
    .visible          (visible),
    .ball_x           (ball_x),
    .ball_y           (ball_y),
    .paddle_x         (paddle_x),
    .restore_bricks   (restore_bricks),
    .frame_pulse      (frame_pulse),
    .collision        (collision),
    .ball_top_col     (ball_top_col),
    .ball_bottom_col  (ball_bottom_col),
    .ball_left_col    (ball_left_col),
    .ball_right_col   (ball_right_col),
    .paddle_collision (paddle_collision),
    .paddle_segment   (paddle_segment),
    .is_border        (is_border),
    .is_brick         (is_brick),
    .is_paddle        (is_paddle),
    .is_ball          (is_ball),
    .bricks_remaining (bricks_remaining),
    .all_cleared      (all_cleared)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // present one pixel, then sample just after the registering edge
  task automatic px(input int h, input int v, input bit vis);
    @(negedge clk);
    hpos    = h[9:0];
    vpos    = v[9:0];
    visible = vis;
    @(posedge clk);
    #1;
  endtask

  task automatic place_ball(input int x, input int y);
    ball_x = x[9:0];
    ball_y = y[8:0];
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_c;
    bit in_b;
    int cnt;
    rst            = 1'b1;
    hpos           = 10'd320;
    vpos           = 10'd240;
    visible        = 1'b0;
    ball_x         = 10'd600;
    ball_y         = 9'd300;
    paddle_x       = 10'd288;
    restore_bricks = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst count", bricks_remaining, 128);
    check("rst cleared", all_cleared, 0);
    check("rst coll", collision, 0);
    check("rst fp", frame_pulse, 0);
    check("rst seg", paddle_segment, 0);
    check("rst brick", is_brick, 0);
    @(negedge clk);
    rst = 1'b0;

    // frame pulse: one cycle, only at (0,480)
    px(639, 479, 0);
    check("fp early", frame_pulse, 0);
    px(0, 480, 0);
    check("fp fire", frame_pulse, 1);
    check("fp nocoll", collision, 0);
    px(1, 480, 0);
    check("fp width", frame_pulse, 0);
    px(0, 481, 0);
    check("fp after", frame_pulse, 0);

    // ball against the left wall
    place_ball(6, 200);
    for (int v = 199; v <= 204; v++) begin
      for (int h = 5; h <= 9; h++) begin
        px(h, v, 1);
        in_b  = (h >= 6 && h <= 9 && v >= 200 && v <= 203);
        exp_c = in_b && (h < 8);
        check($sformatf("wall coll %0d,%0d", h, v),
              collision, exp_c);
        check($sformatf("wall left %0d,%0d", h, v),
              ball_left_col, exp_c && h == 6);
        check($sformatf("wall top %0d,%0d", h, v),
              ball_top_col, exp_c && v == 200);
        check($sformatf("wall bot %0d,%0d", h, v),
              ball_bottom_col, exp_c && v == 203);
        check($sformatf("wall right %0d,%0d", h, v),
              ball_right_col, 0);
        check($sformatf("wall ball %0d,%0d", h, v),
              is_ball, in_b);
      end
    end
    check("wall count", bricks_remaining, 128);

    // paddle contact: offset 32 lands in zone 3
    paddle_x = 10'd288;
    place_ball(320, 450);
    for (int v = 450; v <= 453; v++) begin
      for (int h = 320; h <= 323; h++) begin
        px(h, v, 1);
        check($sformatf("pad pc %0d,%0d", h, v),
              paddle_collision, v >= 452);
        check($sformatf("pad coll %0d,%0d", h, v),
              collision, v >= 452);
        check($sformatf("pad seg %0d,%0d", h, v),
              paddle_segment, (v >= 452) ? 3 : 0);
        check($sformatf("pad bot %0d,%0d", h, v),
              ball_bottom_col, v == 453);
      end
    end
    px(290, 455, 1);
    check("pad z0 seg", paddle_segment, 0);
    check("pad z0 pc", paddle_collision, 0);
    check("pad z0 is", is_paddle, 1);
    px(300, 455, 1);
    check("pad z1 seg", paddle_segment, 1);
    px(330, 455, 1);
    check("pad z4 seg", paddle_segment, 4);
    px(350, 455, 1);
    check("pad z5 seg", paddle_segment, 5);
    px(352, 455, 1);
    check("pad end is", is_paddle, 0);
    check("pad end seg", paddle_segment, 0);

    // brick hit at row 0, col 1
    place_ball(100, 70);
    px(96, 64, 1);
    check("brk pre", is_brick, 1);
    px(100, 70, 1);
    check("brk hit coll", collision, 1);
    check("brk hit is", is_brick, 1);
    check("brk hit cnt", bricks_remaining, 127);
    px(101, 70, 1);
    check("brk again coll", collision, 0);
    check("brk again cnt", bricks_remaining, 127);
    place_ball(600, 300);
    for (int v = 64; v <= 79; v += 5) begin
      for (int h = 96; h <= 127; h += 31) begin
        px(h, v, 1);
        check($sformatf("brk gone %0d,%0d", h, v),
              is_brick, 0);
      end
    end
    px(127, 79, 1);
    check("brk gone corner", is_brick, 0);
    px(95, 64, 1);
    check("brk col0", is_brick, 1);
    px(128, 64, 1);
    check("brk col2", is_brick, 1);
    px(96, 80, 1);
    check("brk row1", is_brick, 1);
    px(63, 64, 1);
    check("brk left out", is_brick, 0);
    check("brk cnt hold", bricks_remaining, 127);

    // refill racing a clear
    place_ball(200, 100);
    restore_bricks = 1'b1;
    px(200, 100, 1);
    restore_bricks = 1'b0;
    check("race cnt", bricks_remaining, 128);
    place_ball(600, 300);
    px(200, 100, 1);
    check("race bit", is_brick, 1);
    px(100, 70, 1);
    check("race restored", is_brick, 1);

    // blanking suppresses everything
    place_ball(6, 200);
    px(6, 200, 0);
    check("blank coll", collision, 0);
    check("blank border", is_border, 0);
    check("blank ball", is_ball, 0);
    check("blank left", ball_left_col, 0);
    place_ball(100, 70);
    px(100, 70, 0);
    check("blank brick", is_brick, 0);
    check("blank cnt", bricks_remaining, 128);

    // clear every brick
    cnt = 128;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 16; c++) begin
        place_ball(64 + c * 32, 64 + r * 16);
        px(64 + c * 32, 64 + r * 16, 1);
        cnt--;
        if (cnt == 1)
          check("clr near", all_cleared, 0);
      end
    end
    check("clr cnt", bricks_remaining, cnt);
    check("clr all", all_cleared, 1);
    place_ball(600, 300);
    px(300, 150, 1);
    check("clr nobrick", is_brick, 0);

    // reset mid-frame acts at once
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid rst cnt", bricks_remaining, 128);
    check("mid rst clr", all_cleared, 0);
    check("mid rst brick", is_brick, 0);
    @(negedge clk);
    rst = 1'b0;
    px(300, 150, 1);
    check("post rst brick", is_brick, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
